// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Owns the inter-stage registers of an in-order pipeline. It tracks per-register
// valid bits, inserts a bubble at the deepest stalled stage, squashes younger work
// on a redirect, steps the fetch PC, latches a sticky halt and keeps performance
// counters. Register r carries the output of stage r into stage r+1.
module pipeline_sequencer #(
    parameter int                   NUM_STAGES    = 32'd5,
    parameter int                   DATA_WIDTH    = 32'd64,
    parameter int                   PC_WIDTH      = 32'd32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC      = {PC_WIDTH{1'b0}},
    parameter int                   COUNTER_WIDTH = 32'd32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0]        stage_out_data,
    input  logic [NUM_STAGES-1:0]                   stage_ready,
    output logic [(NUM_STAGES-1)*DATA_WIDTH-1:0]    stage_in_data,
    output logic [NUM_STAGES-2:0]                   stage_in_valid,
    input  logic                                    flush,
    input  logic [$clog2(NUM_STAGES)-1:0]           flush_stage,
    input  logic [PC_WIDTH-1:0]                     redirect_pc,
    input  logic                                    halt,
    output logic [PC_WIDTH-1:0]                     pc,
    output logic                                    halted,
    output logic                                    drained,
    output logic [COUNTER_WIDTH-1:0]                cycle_count,
    output logic [COUNTER_WIDTH-1:0]                retire_count,
    output logic [COUNTER_WIDTH-1:0]                stall_count
);

    localparam int                      NUM_REGS = NUM_STAGES - 32'sd1;
    localparam int                      FS_WIDTH = $clog2(NUM_STAGES);
    localparam logic [PC_WIDTH-1:0]      PC_STEP  = PC_WIDTH'(3'd4);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1'b1);

    logic [NUM_REGS*DATA_WIDTH-1:0] data_r;
    logic [NUM_REGS*DATA_WIDTH-1:0] data_nxt_s;
    logic [NUM_REGS-1:0]            valid_r;
    logic [NUM_REGS-1:0]            valid_nxt_s;
    logic [NUM_REGS:0]              valid_chain_s;
    logic [PC_WIDTH-1:0]            pc_r;
    logic [PC_WIDTH-1:0]            pc_nxt_s;
    logic                           halted_r;
    logic [COUNTER_WIDTH-1:0]       cycle_r;
    logic [COUNTER_WIDTH-1:0]       retire_r;
    logic [COUNTER_WIDTH-1:0]       stall_cnt_r;

    logic                           stall_s;
    int                             stall_idx_s;
    logic                           fetch_valid_s;
    logic                           flush_ok_s;
    int                             flush_idx_s;
    logic                           retire_s;

    // Fetch stops issuing as soon as a halt is requested and stays stopped once halted.
    assign fetch_valid_s = ~(halted_r | halt);

    // Valid bit each register would inherit when it advances: fetch for register 0,
    // otherwise the register directly upstream.
    assign valid_chain_s = {valid_r, fetch_valid_s};

    // A redirect is only honoured from a real downstream stage; index 0 or out of range is noise.
    assign flush_ok_s  = flush && (flush_stage != {FS_WIDTH{1'b0}}) && (int'(flush_stage) < NUM_STAGES);
    assign flush_idx_s = int'(flush_stage);

    // An instruction leaves the last register only when the final stage accepts it.
    assign retire_s = valid_r[NUM_REGS-1] & stage_ready[NUM_STAGES-1];

    // Find the deepest stage that is not ready; everything upstream of it must wait.
    always_comb begin
        stall_s     = 1'b0;
        stall_idx_s = 32'sd0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (!stage_ready[i]) begin
                stall_s     = 1'b1;
                stall_idx_s = i;
            end else begin
                stall_idx_s = stall_idx_s;
            end
        end
    end

    // Next contents of every inter-stage register: hold, bubble or advance, then squash on redirect.
    always_comb begin
        data_nxt_s  = data_r;
        valid_nxt_s = valid_r;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (stall_s && (r < stall_idx_s)) begin
                data_nxt_s[r*DATA_WIDTH +: DATA_WIDTH] = data_r[r*DATA_WIDTH +: DATA_WIDTH];
                valid_nxt_s[r]                         = valid_r[r];
            end else if (stall_s && (r == stall_idx_s)) begin
                // The stalled stage has produced nothing usable: pass a bubble downstream.
                data_nxt_s[r*DATA_WIDTH +: DATA_WIDTH] = stage_out_data[r*DATA_WIDTH +: DATA_WIDTH];
                valid_nxt_s[r]                         = 1'b0;
            end else begin
                data_nxt_s[r*DATA_WIDTH +: DATA_WIDTH] = stage_out_data[r*DATA_WIDTH +: DATA_WIDTH];
                valid_nxt_s[r]                         = valid_chain_s[r];
            end
            // Work younger than the redirecting stage is wrong-path, even if it was held.
            if (flush_ok_s && (r < flush_idx_s)) begin
                valid_nxt_s[r] = 1'b0;
            end else begin
                valid_nxt_s[r] = valid_nxt_s[r];
            end
        end
    end

    // Fetch PC: a halted core never moves; otherwise redirect beats stall beats sequential step.
    always_comb begin
        pc_nxt_s = pc_r;
        if (halted_r) begin
            pc_nxt_s = pc_r;
        end else if (flush_ok_s) begin
            pc_nxt_s = redirect_pc;
        end else if (stall_s) begin
            pc_nxt_s = pc_r;
        end else begin
            pc_nxt_s = pc_r + PC_STEP;
        end
    end

    // Inter-stage payload and valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= {(NUM_REGS*DATA_WIDTH){1'b0}};
            valid_r <= {NUM_REGS{1'b0}};
        end else begin
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    // Program counter and sticky halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            halted_r <= 1'b0;
        end else begin
            pc_r     <= pc_nxt_s;
            halted_r <= halted_r | halt;
        end
    end

    // Free-running performance counters; all wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_r     <= {COUNTER_WIDTH{1'b0}};
            retire_r    <= {COUNTER_WIDTH{1'b0}};
            stall_cnt_r <= {COUNTER_WIDTH{1'b0}};
        end else begin
            cycle_r <= cycle_r + CNT_ONE;
            if (retire_s) begin
                retire_r <= retire_r + CNT_ONE;
            end else begin
                retire_r <= retire_r;
            end
            if (stall_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign stage_in_data  = data_r;
    assign stage_in_valid = valid_r;
    assign pc             = pc_r;
    assign halted         = halted_r;
    assign drained        = halted_r && (valid_r == {NUM_REGS{1'b0}});
    assign cycle_count    = cycle_r;
    assign retire_count   = retire_r;
    assign stall_count    = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios with literal expectations, a
// randomized run against a per-register behavioural model, and a narrow instance
// used for PC and counter wrap-around.
module tb_pipeline_sequencer;

    localparam int N  = 5;
    localparam int DW = 64;
    localparam int PW = 32;
    localparam int CW = 32;
    localparam int NR = N - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic                 rst;
    logic [N*DW-1:0]      sod;
    logic [N-1:0]         ready;
    logic [NR*DW-1:0]     sid;
    logic [NR-1:0]        siv;
    logic                 flush;
    logic [2:0]           fs;
    logic [PW-1:0]        rpc;
    logic                 halt;
    logic [PW-1:0]        pc;
    logic                 halted, drained;
    logic [CW-1:0]        cyc, ret, stl;

    // Narrow instance: 3 stages, 8-bit data/PC, 4-bit counters
    logic                 rst2;
    logic [23:0]          sod2;
    logic [2:0]           ready2;
    logic [15:0]          sid2;
    logic [1:0]           siv2;
    logic                 flush2;
    logic [1:0]           fs2;
    logic [7:0]           rpc2;
    logic                 halt2;
    logic [7:0]           pc2;
    logic                 halted2, drained2;
    logic [3:0]           cyc2, ret2, stl2;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the main instance
    bit            m_valid [NR];
    logic [DW-1:0] m_data  [NR];
    logic [PW-1:0] m_pc;
    bit            m_halted;
    logic [CW-1:0] m_cyc, m_ret, m_stl;

    pipeline_sequencer #(.NUM_STAGES(N), .DATA_WIDTH(DW), .PC_WIDTH(PW),
                         .RESET_PC(32'h0), .COUNTER_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .stage_out_data(sod), .stage_ready(ready),
        .stage_in_data(sid), .stage_in_valid(siv), .flush(flush), .flush_stage(fs),
        .redirect_pc(rpc), .halt(halt), .pc(pc), .halted(halted), .drained(drained),
        .cycle_count(cyc), .retire_count(ret), .stall_count(stl));

    pipeline_sequencer #(.NUM_STAGES(3), .DATA_WIDTH(8), .PC_WIDTH(8),
                         .RESET_PC(8'hF0), .COUNTER_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst2), .stage_out_data(sod2), .stage_ready(ready2),
        .stage_in_data(sid2), .stage_in_valid(siv2), .flush(flush2), .flush_stage(fs2),
        .redirect_pc(rpc2), .halt(halt2), .pc(pc2), .halted(halted2), .drained(drained2),
        .cycle_count(cyc2), .retire_count(ret2), .stall_count(stl2));

    // One clock of the model, derived directly from the stall/flush/halt rules.
    task automatic model_step();
        int k;
        bit fv;
        bit acc;
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_valid[r] = 1'b0;
                m_data[r]  = '0;
            end
            m_pc = 32'h0; m_halted = 1'b0;
            m_cyc = '0; m_ret = '0; m_stl = '0;
        end else begin
            k = -1;
            for (int i = 0; i < N; i++) if (!ready[i]) k = i;
            fv  = !(m_halted || halt);
            acc = flush && (int'(fs) >= 1) && (int'(fs) <= N - 1);
            m_cyc = m_cyc + 1;
            if (m_valid[NR-1] && ready[N-1]) m_ret = m_ret + 1;
            if (k >= 0) m_stl = m_stl + 1;
            // Walk downstream-first so each register sees its neighbour's old valid.
            for (int r = NR - 1; r >= 0; r--) begin
                if (k > r) begin
                    m_valid[r] = m_valid[r];
                end else if (k == r) begin
                    m_valid[r] = 1'b0;
                    m_data[r]  = sod[r*DW +: DW];
                end else begin
                    if (r == 0) m_valid[r] = fv;
                    else        m_valid[r] = m_valid[r-1];
                    m_data[r] = sod[r*DW +: DW];
                end
                if (acc && (r < int'(fs))) m_valid[r] = 1'b0;
            end
            if (m_halted)      m_pc = m_pc;
            else if (acc)      m_pc = rpc;
            else if (k >= 0)   m_pc = m_pc;
            else               m_pc = m_pc + 32'd4;
            if (halt) m_halted = 1'b1;
        end
    endtask

    function automatic logic [NR-1:0] m_vvec();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = m_valid[r];
        return v;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) sod[i*DW +: DW] = {$urandom(), $urandom()};
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = '1; flush = 1'b0; fs = 3'd0; rpc = '0; halt = 1'b0;
        rand_data();
        tick();
        tick();
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        n_checks++; if (siv !== 4'b0000) begin n_errors++; $display("FAIL reset_valid: got %b expected %b", siv, 4'b0000); end
        n_checks++; if (sid !== '0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", sid); end
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_checks++; if (drained !== 1'b0) begin n_errors++; $display("FAIL reset_drained: got %b expected 0", drained); end
        n_checks++; if ({cyc, ret, stl} !== '0) begin n_errors++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", cyc, ret, stl); end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        logic [NR-1:0] ev;
        logic [N*DW-1:0] drv;
        for (int n = 1; n <= 6; n++) begin
            rand_data();
            drv = sod;
            tick();
            ev = '0;
            for (int i = 0; i < n && i < NR; i++) ev[i] = 1'b1;
            n_checks++; if (pc !== 32'(4 * n)) begin n_errors++; $display("FAIL free_pc n=%0d: got %h expected %h", n, pc, 32'(4 * n)); end
            n_checks++; if (siv !== ev) begin n_errors++; $display("FAIL free_valid n=%0d: got %b expected %b", n, siv, ev); end
            for (int r = 0; r < NR; r++) begin
                n_checks++;
                if (sid[r*DW +: DW] !== drv[r*DW +: DW]) begin n_errors++; $display("FAIL free_data n=%0d r=%0d: got %h expected %h", n, r, sid[r*DW +: DW], drv[r*DW +: DW]); end
            end
            if (n == 5) begin
                n_checks++; if (ret !== 32'd1) begin n_errors++; $display("FAIL free_retire: got %0d expected 1", ret); end
            end
        end
        n_checks++; if (cyc !== 32'd6) begin n_errors++; $display("FAIL free_cycles: got %0d expected 6", cyc); end
    endtask

    task automatic test_stall();
        logic [N*DW-1:0] held;
        logic [NR-1:0] ev;
        held = sod;
        ready = 5'b11011;
        for (int c = 1; c <= 3; c++) begin
            rand_data();
            tick();
            ev = (c == 1) ? 4'b1011 : 4'b0011;
            n_checks++; if (pc !== 32'h18) begin n_errors++; $display("FAIL stall_pc c=%0d: got %h expected %h", c, pc, 32'h18); end
            n_checks++; if (siv !== ev) begin n_errors++; $display("FAIL stall_valid c=%0d: got %b expected %b", c, siv, ev); end
            n_checks++; if (sid[2*DW-1:0] !== held[2*DW-1:0]) begin n_errors++; $display("FAIL stall_hold_data c=%0d: got %h expected %h", c, sid[2*DW-1:0], held[2*DW-1:0]); end
            n_checks++; if (stl !== 32'(c)) begin n_errors++; $display("FAIL stall_count c=%0d: got %0d expected %0d", c, stl, c); end
        end
        ready = '1;
        rand_data();
        tick();
        n_checks++; if (siv !== 4'b0111) begin n_errors++; $display("FAIL stall_release_valid: got %b expected 0111", siv); end
        n_checks++; if (pc !== 32'h1C) begin n_errors++; $display("FAIL stall_release_pc: got %h expected 1c", pc); end
    endtask

    task automatic test_flush();
        logic [N*DW-1:0] drv;
        flush = 1'b1; fs = 3'd2; rpc = 32'h100;
        rand_data();
        drv = sod;
        tick();
        flush = 1'b0;
        n_checks++; if (siv !== 4'b1100) begin n_errors++; $display("FAIL flush_valid: got %b expected 1100", siv); end
        n_checks++; if (pc !== 32'h100) begin n_errors++; $display("FAIL flush_pc: got %h expected 100", pc); end
        n_checks++; if (sid[2*DW +: 2*DW] !== drv[2*DW +: 2*DW]) begin n_errors++; $display("FAIL flush_adv_data: got %h expected %h", sid[2*DW +: 2*DW], drv[2*DW +: 2*DW]); end
        rand_data();
        tick();
        n_checks++; if (pc !== 32'h104) begin n_errors++; $display("FAIL flush_pc_next: got %h expected 104", pc); end
        n_checks++; if (siv !== 4'b1001) begin n_errors++; $display("FAIL flush_valid_next: got %b expected 1001", siv); end
    endtask

    task automatic test_flush_stall();
        ready = 5'b11101; flush = 1'b1; fs = 3'd3; rpc = 32'h2A0;
        rand_data();
        tick();
        flush = 1'b0; ready = '1;
        n_checks++; if (siv !== 4'b0000) begin n_errors++; $display("FAIL flstall_valid: got %b expected 0000", siv); end
        n_checks++; if (pc !== 32'h2A0) begin n_errors++; $display("FAIL flstall_pc: got %h expected 2a0", pc); end
        n_checks++; if (stl !== 32'd4) begin n_errors++; $display("FAIL flstall_count: got %0d expected 4", stl); end
        rand_data();
        tick();
        n_checks++; if (pc !== 32'h2A4) begin n_errors++; $display("FAIL flstall_pc_next: got %h expected 2a4", pc); end
        n_checks++; if (siv !== 4'b0001) begin n_errors++; $display("FAIL flstall_valid_next: got %b expected 0001", siv); end
    endtask

    task automatic test_bad_flush();
        logic [PW-1:0] ep;
        logic [NR-1:0] ev;
        logic [2:0] bad [4];
        bad[0] = 3'd0; bad[1] = 3'd5; bad[2] = 3'd6; bad[3] = 3'd7;
        ep = 32'h2A4; ev = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            flush = 1'b1; fs = bad[i]; rpc = 32'hDEAD0000;
            rand_data();
            tick();
            ep = ep + 32'd4;
            ev = {ev[NR-2:0], 1'b1};
            n_checks++; if (pc !== ep) begin n_errors++; $display("FAIL badflush_pc fs=%0d: got %h expected %h", bad[i], pc, ep); end
            n_checks++; if (siv !== ev) begin n_errors++; $display("FAIL badflush_valid fs=%0d: got %b expected %b", bad[i], siv, ev); end
        end
        flush = 1'b0; fs = 3'd0;
    endtask

    task automatic test_halt();
        logic [NR-1:0] ev;
        halt = 1'b1;
        rand_data();
        tick();
        halt = 1'b0;
        n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_set: got %b expected 1", halted); end
        n_checks++; if (siv !== 4'b1110) begin n_errors++; $display("FAIL halt_valid: got %b expected 1110", siv); end
        n_checks++; if (pc !== 32'h2B8) begin n_errors++; $display("FAIL halt_pc: got %h expected 2b8", pc); end
        n_checks++; if (drained !== 1'b0) begin n_errors++; $display("FAIL halt_drained_early: got %b expected 0", drained); end
        for (int c = 2; c <= 4; c++) begin
            rand_data();
            tick();
            ev = 4'b1111 << c;
            n_checks++; if (pc !== 32'h2B8) begin n_errors++; $display("FAIL halt_pc_frozen c=%0d: got %h expected 2b8", c, pc); end
            n_checks++; if (siv !== ev) begin n_errors++; $display("FAIL halt_drain_valid c=%0d: got %b expected %b", c, siv, ev); end
            n_checks++; if (drained !== (c == 4)) begin n_errors++; $display("FAIL halt_drained c=%0d: got %b expected %b", c, drained, (c == 4)); end
        end
        flush = 1'b1; fs = 3'd1; rpc = 32'h400;
        tick();
        flush = 1'b0;
        n_checks++; if (pc !== 32'h2B8) begin n_errors++; $display("FAIL halt_flush_pc: got %h expected 2b8", pc); end
        n_checks++; if (halted !== 1'b1 || drained !== 1'b1) begin n_errors++; $display("FAIL halt_sticky: got halted=%b drained=%b expected 1/1", halted, drained); end
    endtask

    task automatic test_reset_mid_stall();
        ready = 5'b10111; halt = 1'b1; flush = 1'b1; fs = 3'd2; rpc = 32'h500; rst = 1'b1;
        tick();
        rst = 1'b0; halt = 1'b0; flush = 1'b0; ready = '1;
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL rstmid_pc: got %h expected 0", pc); end
        n_checks++; if (siv !== 4'b0000) begin n_errors++; $display("FAIL rstmid_valid: got %b expected 0000", siv); end
        n_checks++; if ({cyc, ret, stl} !== '0) begin n_errors++; $display("FAIL rstmid_counters: got %0d/%0d/%0d expected 0/0/0", cyc, ret, stl); end
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL rstmid_halted: got %b expected 0", halted); end
        rand_data();
        tick();
        n_checks++; if (pc !== 32'h4) begin n_errors++; $display("FAIL rstmid_first_step: got %h expected 4", pc); end
        n_checks++; if (siv !== 4'b0001) begin n_errors++; $display("FAIL rstmid_first_valid: got %b expected 0001", siv); end
        n_checks++; if (cyc !== 32'd1) begin n_errors++; $display("FAIL rstmid_cycles: got %0d expected 1", cyc); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            rst   = ($urandom_range(0, 59) == 0);
            halt  = ($urandom_range(0, 89) == 0);
            flush = ($urandom_range(0, 6) == 0);
            fs    = 3'($urandom_range(0, 7));
            rpc   = $urandom() & 32'hFFFF_FFFC;
            for (int i = 0; i < N; i++) ready[i] = ($urandom_range(0, 7) != 0);
            rand_data();
            tick();
            n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rand_pc t=%0d: got %h expected %h", t, pc, m_pc); end
            n_checks++; if (siv !== m_vvec()) begin n_errors++; $display("FAIL rand_valid t=%0d: got %b expected %b", t, siv, m_vvec()); end
            for (int r = 0; r < NR; r++) begin
                if (m_valid[r]) begin
                    n_checks++;
                    if (sid[r*DW +: DW] !== m_data[r]) begin n_errors++; $display("FAIL rand_data t=%0d r=%0d: got %h expected %h", t, r, sid[r*DW +: DW], m_data[r]); end
                end
            end
            n_checks++; if (halted !== m_halted) begin n_errors++; $display("FAIL rand_halted t=%0d: got %b expected %b", t, halted, m_halted); end
            n_checks++; if (drained !== (m_halted && (m_vvec() == '0))) begin n_errors++; $display("FAIL rand_drained t=%0d: got %b expected %b", t, drained, (m_halted && (m_vvec() == '0))); end
            n_checks++; if (cyc !== m_cyc) begin n_errors++; $display("FAIL rand_cycles t=%0d: got %0d expected %0d", t, cyc, m_cyc); end
            n_checks++; if (ret !== m_ret) begin n_errors++; $display("FAIL rand_retire t=%0d: got %0d expected %0d", t, ret, m_ret); end
            n_checks++; if (stl !== m_stl) begin n_errors++; $display("FAIL rand_stalls t=%0d: got %0d expected %0d", t, stl, m_stl); end
        end
        rst = 1'b0; halt = 1'b0; flush = 1'b0; ready = '1;
    endtask

    task automatic test_wrap();
        logic [7:0] ep;
        logic [3:0] er;
        n_checks++; if (pc2 !== 8'hF0 || cyc2 !== 4'd0) begin n_errors++; $display("FAIL wrap_reset: got pc=%h cyc=%0d expected f0/0", pc2, cyc2); end
        rst2 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            sod2 = 24'($urandom());
            tick();
            ep = 8'hF0 + 8'(4 * n);
            er = (n >= 3) ? 4'(n - 2) : 4'd0;
            n_checks++; if (pc2 !== ep) begin n_errors++; $display("FAIL wrap_pc n=%0d: got %h expected %h", n, pc2, ep); end
            n_checks++; if (cyc2 !== 4'(n)) begin n_errors++; $display("FAIL wrap_cycles n=%0d: got %0d expected %0d", n, cyc2, 4'(n)); end
            n_checks++; if (ret2 !== er) begin n_errors++; $display("FAIL wrap_retire n=%0d: got %0d expected %0d", n, ret2, er); end
        end
        n_checks++; if (stl2 !== 4'd0) begin n_errors++; $display("FAIL wrap_stalls: got %0d expected 0", stl2); end
    endtask

    initial begin
        rst = 1'b1; ready = '1; flush = 1'b0; fs = 3'd0; rpc = '0; halt = 1'b0; sod = '0;
        rst2 = 1'b1; sod2 = '0; ready2 = '1; flush2 = 1'b0; fs2 = 2'd0; rpc2 = 8'h0; halt2 = 1'b0;
        #1;
        test_reset();
        test_free_run();
        test_stall();
        test_flush();
        test_flush_stall();
        test_bad_flush();
        test_halt();
        test_reset_mid_stall();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
